// File: rtl/hcm_reader.sv
// HCM row reader: issues credit-limited SSID reads, checks response order, and
// buffers decoded records. Define HCM_READER_ZERO_FILTER_EN to drop zero-count rows.
module hcm_reader #(
    parameter int ROWINDEXBITS_HCM = 10,
    parameter int MAXHITNBITS      = 3,
    parameter int ROWINDEXBITS_HIM = 8,
    parameter int MAXINFLIGHT      = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    ssidValid,
    output logic                                    ssidReady,
    input  logic [ROWINDEXBITS_HCM-1:0]             ssidIn,
    input  logic                                    flush,
    input  logic                                    hcmReadReady,
    output logic                                    readRow,
    output logic [ROWINDEXBITS_HCM-1:0]             inputRowToRead,
    input  logic                                    hcmRowValid,
    input  logic [ROWINDEXBITS_HCM-1:0]             hcmRowPassed,
    input  logic [MAXHITNBITS+ROWINDEXBITS_HIM-1:0] hcmRowData,
    output logic                                    outValid,
    input  logic                                    outReady,
    output logic [ROWINDEXBITS_HCM-1:0]             outSSID,
    output logic [MAXHITNBITS-1:0]                  outNHits,
    output logic [ROWINDEXBITS_HIM-1:0]             outHIMAddress,
    output logic                                    done,
    output logic                                    orderError,
    output logic                                    busy
);

    localparam int NCOLS_HCM = MAXHITNBITS + ROWINDEXBITS_HIM;
    localparam int PW        = $clog2(MAXINFLIGHT);
    localparam int CW        = $clog2(MAXINFLIGHT + 1);
    localparam int RW        = ROWINDEXBITS_HCM + NCOLS_HCM;
    localparam logic [CW:0]   LIMIT = (CW+1)'(MAXINFLIGHT);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                      r_state;
    logic                        r_done;
    logic                        r_readRow;
    logic [ROWINDEXBITS_HCM-1:0] r_rowToRead;
    logic                        r_orderError;
    logic [CW-1:0]               r_inflight;
    logic [CW-1:0]               r_fifo_cnt;
    logic [PW-1:0]               r_exp_wr;
    logic [PW-1:0]               r_exp_rd;
    logic [PW-1:0]               r_rec_wr;
    logic [PW-1:0]               r_rec_rd;
    logic [ROWINDEXBITS_HCM-1:0] r_exp_mem [MAXINFLIGHT];
    logic [RW-1:0]               r_rec_mem [MAXINFLIGHT];

    logic                        w_accept;
    logic                        w_resp;
    logic                        w_rec_push;
    logic                        w_pop;
    logic                        w_order_bad;
    logic [CW:0]                 w_credit;
    logic [CW-1:0]               w_inflight_nxt;
    logic [CW-1:0]               w_cnt_nxt;
    logic [RW-1:0]               w_rec;
    logic [RW-1:0]               w_head;

    // Credits cover both outstanding reads and buffered records, so the record FIFO cannot overflow.
    assign w_credit  = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
    assign ssidReady = (r_state != S_FLUSH) && !flush && hcmReadReady && (w_credit < LIMIT);
    assign w_accept  = ssidValid && ssidReady;

    assign w_resp      = hcmRowValid && (r_inflight != '0);
    assign w_order_bad = hcmRowValid &&
                         ((r_inflight == '0) || (r_exp_mem[r_exp_rd] != hcmRowPassed));

`ifdef HCM_READER_ZERO_FILTER_EN
    assign w_rec_push = w_resp && (hcmRowData[MAXHITNBITS-1:0] != '0);
`else
    assign w_rec_push = w_resp;
`endif

    assign outValid = (r_fifo_cnt != '0);
    assign w_pop    = outValid && outReady;

    assign w_rec  = {hcmRowPassed, hcmRowData[MAXHITNBITS-1:0], hcmRowData[NCOLS_HCM-1:MAXHITNBITS]};
    assign w_head = r_rec_mem[r_rec_rd];

    assign outSSID       = w_head[RW-1 -: ROWINDEXBITS_HCM];
    assign outNHits      = w_head[ROWINDEXBITS_HIM +: MAXHITNBITS];
    assign outHIMAddress = w_head[ROWINDEXBITS_HIM-1:0];

    assign readRow        = r_readRow;
    assign inputRowToRead = r_rowToRead;
    assign done           = r_done;
    assign orderError     = r_orderError;
    assign busy           = (r_state != S_IDLE);

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_accept && !w_resp)
            w_inflight_nxt = r_inflight + C_ONE;
        else if (!w_accept && w_resp)
            w_inflight_nxt = r_inflight - C_ONE;
    end

    always_comb begin
        w_cnt_nxt = r_fifo_cnt;
        if (w_rec_push && !w_pop)
            w_cnt_nxt = r_fifo_cnt + C_ONE;
        else if (!w_rec_push && w_pop)
            w_cnt_nxt = r_fifo_cnt - C_ONE;
    end

    // Done is registered from next-cycle counts so it lands in the first cycle with nothing left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE:  if (ssidValid || flush) r_state <= S_RUN;
                S_RUN:   if (flush) r_state <= S_FLUSH;
                S_FLUSH: begin
                    if ((w_inflight_nxt == '0) && (w_cnt_nxt == '0)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readRow    <= 1'b0;
            r_rowToRead  <= '0;
            r_orderError <= 1'b0;
            r_inflight   <= '0;
            r_fifo_cnt   <= '0;
            r_exp_wr     <= '0;
            r_exp_rd     <= '0;
            r_rec_wr     <= '0;
            r_rec_rd     <= '0;
        end else begin
            r_readRow  <= w_accept;
            r_inflight <= w_inflight_nxt;
            r_fifo_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_rowToRead <= ssidIn;
                r_exp_wr    <= r_exp_wr + P_ONE;
            end
            if (w_resp)
                r_exp_rd <= r_exp_rd + P_ONE;
            if (w_order_bad)
                r_orderError <= 1'b1;
            if (w_rec_push)
                r_rec_wr <= r_rec_wr + P_ONE;
            if (w_pop)
                r_rec_rd <= r_rec_rd + P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_exp_mem[r_exp_wr] <= ssidIn;
        if (w_rec_push)
            r_rec_mem[r_rec_wr] <= w_rec;
    end

endmodule

// File: doc/hcm_reader.md
HCM_READER -- requirements
Module: hcm_reader

Interface
REQ-001 SHALL have parameter ROWINDEXBITS_HCM, default 10, SSID/HCM row address width.
REQ-002 SHALL have parameter MAXHITNBITS, default 3, hit-count field width (HCM row bits [MAXHITNBITS-1:0]).
REQ-003 SHALL have parameter ROWINDEXBITS_HIM, default 8, HIM address field width (HCM row bits above the count); NCOLS_HCM = MAXHITNBITS+ROWINDEXBITS_HIM.
REQ-004 SHALL have parameter MAXINFLIGHT, default 4, power of two, maximum reads outstanding plus records buffered.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 ssidValid / ssidReady  in / out  1 / 1  SSID request handshake.
REQ-008 ssidIn  in  ROWINDEXBITS_HCM  row to read out.
REQ-009 flush  in  1  end-of-event pulse; finish outstanding work.
REQ-010 hcmReadReady  in  1  HCM can accept reads.
REQ-011 readRow / inputRowToRead  out  1 / ROWINDEXBITS_HCM  read request to HCM.
REQ-012 hcmRowValid  in  1  one-cycle strobe: hcmRowPassed/hcmRowData carry a response.
REQ-013 hcmRowPassed / hcmRowData  in  ROWINDEXBITS_HCM / NCOLS_HCM  returned row index and contents.
REQ-014 outValid / outReady  out / in  1 / 1  record handshake.
REQ-015 outSSID / outNHits / outHIMAddress  out  ROWINDEXBITS_HCM / MAXHITNBITS / ROWINDEXBITS_HIM  decoded record.
REQ-016 done  out  1  one-cycle pulse, flush complete.
REQ-017 orderError  out  1  sticky: response row differed from expected row.
REQ-018 busy  out  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH: IDLE->RUN on ssidValid or flush; RUN->FLUSH on flush; FLUSH->IDLE when inFlight==0 and record FIFO empty, asserting done for that one cycle.
REQ-020 SHALL compute ssidReady = (state==RUN or IDLE) && !flush && hcmReadReady && (inFlight + fifoCount) < MAXINFLIGHT, combinationally; ssidReady SHALL be 0 in FLUSH.
REQ-021 On accept (ssidValid&&ssidReady) at cycle N, readRow SHALL be 1 and inputRowToRead = ssidIn in cycle N+1 (registered), otherwise readRow 0; inFlight SHALL increment.
REQ-022 Each accepted SSID SHALL be pushed into an expected-row FIFO (depth MAXINFLIGHT); each hcmRowValid SHALL pop it and compare with hcmRowPassed; mismatch SHALL set orderError until reset.
REQ-023 On hcmRowValid, inFlight SHALL decrement and the record {hcmRowPassed, hcmRowData[MAXHITNBITS-1:0], hcmRowData[NCOLS_HCM-1:MAXHITNBITS]} SHALL be written to a record FIFO (depth MAXINFLIGHT); outValid SHALL assert the following cycle.
REQ-024 Simultaneous accept and response in one cycle SHALL leave inFlight unchanged; simultaneous push and pop of record FIFO SHALL leave fifoCount unchanged.
REQ-025 outValid = record FIFO non-empty; outputs SHALL hold stable while outValid && !outReady; pop on outValid&&outReady.
REQ-026 Credit rule guarantees no record FIFO overflow; hcmRowValid with inFlight==0 SHALL be ignored and set orderError.
REQ-027 Pointers SHALL wrap modulo MAXINFLIGHT; FIFO full at count==MAXINFLIGHT.
REQ-028 Records SHALL be emitted in request order.

Reset
REQ-029 Reset SHALL force state IDLE, readRow 0, inputRowToRead 0, inFlight 0, both FIFOs empty, outValid 0, done 0, orderError 0, busy 0; reset mid-operation discards all outstanding requests and records, and responses arriving afterwards are handled per REQ-026.

Configuration
REQ-030 Macro HCM_READER_ZERO_FILTER_EN: when defined, responses with count field 0 SHALL be dropped (not written to record FIFO; inFlight still decrements, order still checked); when undefined, all responses SHALL be emitted.

Verification
REQ-031 Single read: ssidIn=0x05 accepted, response hcmRowData={HIM 0x12, count 3} -> outSSID 0x05, outNHits 3, outHIMAddress 0x12, outValid one cycle after hcmRowValid.
REQ-032 Backpressure: outReady=0, 6 SSIDs offered, no responses -> exactly 4 accepted, ssidReady 0; after 4 responses and 4 outReady pops, remaining 2 accepted.
REQ-033 Order check: request 0x01,0x02; respond 0x02 first -> orderError=1 and stays 1 until reset.
REQ-034 Flush: flush with 2 reads in flight -> done pulses exactly once, cycle after last record popped; busy falls to 0.
REQ-035 Zero filter: with HCM_READER_ZERO_FILTER_EN, response count 0 -> no outValid, inFlight returns to 0; without macro -> record emitted with outNHits 0.
REQ-036 Reset mid-run with 3 in flight -> all outputs at reset values next cycle; a late hcmRowValid sets orderError only.
